// File: rtl/onchip_mem_dp.sv
// onchip_mem_dp: dual-slave Avalon-MM on-chip RAM with byte enables, collision rules,
// optional clear-on-reset sequencer and a 1- or 2-cycle read pipeline.
module onchip_mem_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = "onchip_mem.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    output logic                    init_done,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_addr, clr_nx;
    logic                  ce, stall, clearing;
    logic [1:0]            cs, rd, wr, acc, re;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [NB-1:0]         be [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rvalid [2];
    logic                  wa_en, wb_en;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_data;
    logic [NB-1:0]         wa_be;

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign ce        = ~reset_req;
    assign stall     = reset | reset_req | (state == CLEAR);
    assign clearing  = (state == CLEAR) & ~reset;
    assign init_done = (state == RUN) & ~reset;

    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;

    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};
    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    // A write on a port wins over a simultaneous read on that port.
    assign acc = cs & (rd | wr) & {2{~stall}};
    assign re  = acc & rd & ~wr;

    // Port A is shared between the clear sequencer and s1.
    assign wa_en   = clearing | (acc[0] & wr[0]);
    assign wa_addr = clearing ? clr_addr : addr[0];
    assign wa_data = clearing ? '0 : wdata[0];
    assign wa_be   = clearing ? '1 : be[0];
    // s1 owns the whole word on a same-address write collision.
    assign wb_en   = acc[1] & wr[1] & ~(wa_en && wa_addr == addr[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr <= '0;
        end else if (ce) begin
            state    <= state_nx;
            clr_addr <= clr_nx;
        end
    end

    always_comb begin
        state_nx = (state == CLEAR && &clr_addr) ? RUN : state;
        clr_nx   = (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < NB; i++) begin
                if (wa_en && wa_be[i]) mem[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
                if (wb_en && be[1][i]) mem[addr[1]][i*8 +: 8] <= wdata[1][i*8 +: 8];
            end
        end
    end

    // Stage 0 is the synchronous RAM read (old data on read-during-write);
    // READ_LATENCY output stages follow, each loading only on a valid beat.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] q [READ_LATENCY+1];
        logic [READ_LATENCY:0] v;
        always_ff @(posedge clk) begin
            if (reset) begin
                v <= '0;
                for (int i = 0; i <= READ_LATENCY; i++) q[i] <= '0;
            end else if (ce) begin
                v <= {v[READ_LATENCY-1:0], re[p]};
                if (re[p]) q[0] <= mem[addr[p]];
                for (int i = 1; i <= READ_LATENCY; i++) if (v[i-1]) q[i] <= q[i-1];
            end
        end
        assign rdata[p]  = q[READ_LATENCY];
        assign rvalid[p] = v[READ_LATENCY] & ~reset_req & ~reset;
    end

    assign s1_readdata      = rdata[0];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdata      = rdata[1];
    assign s2_readdatavalid = rvalid[1];
endmodule

// File: tb/tb_onchip_mem_dp.sv
// tb_onchip_mem_dp: directed checks of clear sequencing, byte enables, collisions,
// read-during-write, reset_req freeze with a 2-cycle pipeline, and reset mid-clear.
module tb_onchip_mem_dp;
    logic clk = 0;
    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int cnt, np, first, last;

    logic        reset = 1, reset_req = 0, init_done;
    logic [11:0] s1_address = 0, s2_address = 0;
    logic        s1_chipselect = 0, s1_read = 0, s1_write = 0;
    logic        s2_chipselect = 0, s2_read = 0, s2_write = 0;
    logic [3:0]  s1_byteenable = 0, s2_byteenable = 0;
    logic [31:0] s1_writedata = 0, s2_writedata = 0;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;

    logic        b_reset = 1, b_reset_req = 0, b_cs = 0, b_read = 0, b_write = 0;
    logic [3:0]  b_address = 0;
    logic [31:0] b_writedata = 0, b_readdata, b_s1_readdata;
    logic        b_readdatavalid, b_waitrequest, b_init_done;
    logic        b_s1_readdatavalid, b_s1_waitrequest;

    onchip_mem_dp dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .init_done(init_done),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
    );

    onchip_mem_dp #(.ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(b_reset), .reset_req(b_reset_req), .init_done(b_init_done),
        .s1_address(4'd0), .s1_chipselect(1'b0), .s1_read(1'b0),
        .s1_write(1'b0), .s1_byteenable(4'd0), .s1_writedata(32'd0),
        .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid), .s1_waitrequest(b_s1_waitrequest),
        .s2_address(b_address), .s2_chipselect(b_cs), .s2_read(b_read),
        .s2_write(b_write), .s2_byteenable(4'hF), .s2_writedata(b_writedata),
        .s2_readdata(b_readdata), .s2_readdatavalid(b_readdatavalid), .s2_waitrequest(b_waitrequest)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
    endtask

    task automatic wr(input int port, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        if (port == 1) begin
            s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
        @(negedge clk);
        idle();
    endtask

    // Accept at the next edge; valid must be absent one cycle later and present the cycle after.
    task automatic rd(input int port, input logic [11:0] a, input logic [31:0] exp, input string tag);
        if (port == 1) begin
            s1_chipselect = 1; s1_read = 1; s1_address = a;
        end else begin
            s2_chipselect = 1; s2_read = 1; s2_address = a;
        end
        check({tag, "_wait"}, {31'd0, port == 1 ? s1_waitrequest : s2_waitrequest}, 32'd0);
        @(negedge clk);
        idle();
        check({tag, "_early"}, {31'd0, port == 1 ? s1_readdatavalid : s2_readdatavalid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, port == 1 ? s1_readdatavalid : s2_readdatavalid}, 32'd1);
        check({tag, "_data"}, port == 1 ? s1_readdata : s2_readdata, exp);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_rdata1", s1_readdata, 32'd0);
        check("rst_rdata2", s2_readdata, 32'd0);
        check("rst_flags", {28'd0, s1_readdatavalid, s2_readdatavalid, s1_waitrequest, init_done}, 32'h2);
        check("rst_b_s1", b_s1_readdata | {31'd0, b_s1_readdatavalid}, 32'd0);
        reset = 0; b_reset = 0;
        cnt = 0;
        @(negedge clk); cnt++;
        check("b_ready", {29'd0, b_s1_waitrequest, b_waitrequest, b_init_done}, 32'd1);
        while (s1_waitrequest && cnt < 5000) begin
            @(negedge clk); cnt++;
        end
        check("clear_len", cnt, 32'd4096);
        check("init_done", {30'd0, init_done, s2_waitrequest}, 32'h2);

        rd(1, 12'd0, 32'h0, "clr_0");
        rd(2, 12'd2047, 32'h0, "clr_2047");
        rd(1, 12'd4095, 32'h0, "clr_4095");

        wr(1, 12'd5, 32'hAABBCCDD, 4'hF);
        wr(1, 12'd5, 32'h11223344, 4'b0101);
        rd(2, 12'd5, 32'hAA22CC44, "byteen");
        @(negedge clk);
        check("hold_valid", {31'd0, s2_readdatavalid}, 32'd0);
        check("hold_data", s2_readdata, 32'hAA22CC44);

        s1_chipselect = 1; s1_write = 1; s1_address = 7; s1_writedata = 32'h12345678; s1_byteenable = 4'hF;
        s2_chipselect = 1; s2_write = 1; s2_address = 7; s2_writedata = 32'h87654321; s2_byteenable = 4'hF;
        @(negedge clk);
        idle();
        s1_chipselect = 1; s1_read = 1; s1_address = 7;
        s2_chipselect = 1; s2_read = 1; s2_address = 7;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("coll_valid", {30'd0, s1_readdatavalid, s2_readdatavalid}, 32'h3);
        check("coll_s1", s1_readdata, 32'h12345678);
        check("coll_s2", s2_readdata, 32'h12345678);

        s1_chipselect = 1; s1_write = 1; s1_address = 9; s1_writedata = 32'hFFFF0000; s1_byteenable = 4'hF;
        s2_chipselect = 1; s2_read = 1; s2_address = 9;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("rdw21_valid", {31'd0, s2_readdatavalid}, 32'd1);
        check("rdw21_old", s2_readdata, 32'h0);
        rd(2, 12'd9, 32'hFFFF0000, "rdw21_new");

        s2_chipselect = 1; s2_write = 1; s2_address = 10; s2_writedata = 32'h0BADF00D; s2_byteenable = 4'hF;
        s1_chipselect = 1; s1_read = 1; s1_address = 10;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("rdw12_valid", {31'd0, s1_readdatavalid}, 32'd1);
        check("rdw12_old", s1_readdata, 32'h0);
        rd(1, 12'd10, 32'h0BADF00D, "rdw12_new");

        s1_chipselect = 1; s1_read = 1; s1_write = 1; s1_address = 11;
        s1_writedata = 32'h5A5A5A5A; s1_byteenable = 4'hF;
        @(negedge clk);
        idle();
        check("rw_noread1", {31'd0, s1_readdatavalid}, 32'd0);
        @(negedge clk);
        check("rw_noread2", {31'd0, s1_readdatavalid}, 32'd0);
        rd(2, 12'd11, 32'h5A5A5A5A, "rw_write");

        b_cs = 1; b_write = 1;
        for (int i = 0; i < 8; i++) begin
            b_address = i[3:0];
            b_writedata = 32'hC0DE0000 + i;
            @(negedge clk);
        end
        b_cs = 0; b_write = 0;
        np = 0; first = -1; last = -1;
        fork
            begin
                b_cs = 1; b_read = 1;
                for (int i = 0; i < 8; i++) begin
                    b_address = i[3:0];
                    if (i == 4) begin
                        b_reset_req = 1;
                        repeat (3) @(negedge clk);
                        b_reset_req = 0;
                    end
                    @(negedge clk);
                end
                b_cs = 0; b_read = 0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    if (b_readdatavalid) begin
                        if (np < 8) check("l2_data", b_readdata, 32'hC0DE0000 + np);
                        if (np == 0) first = c;
                        last = c;
                        np++;
                    end
                end
            end
        join
        check("l2_count", np, 32'd8);
        check("l2_span", last - first, 32'd10);
        check("l2_hold", b_readdata, 32'hC0DE0007);

        s2_chipselect = 1; s2_read = 1; s2_address = 5;
        @(negedge clk);
        idle();
        reset = 1;
        @(negedge clk);
        check("rst_kill_valid", {31'd0, s2_readdatavalid}, 32'd0);
        check("rst_kill_data", s2_readdata, 32'd0);
        @(negedge clk);
        reset = 0;
        repeat (100) @(negedge clk);
        check("midclr_busy", {30'd0, s1_waitrequest, init_done}, 32'h2);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        cnt = 0;
        while ((s1_waitrequest || !init_done) && cnt < 5000) begin
            @(negedge clk); cnt++;
        end
        check("midclr_len", cnt, 32'd4096);
        rd(1, 12'd7, 32'h0, "reclr_7");
        rd(2, 12'd10, 32'h0, "reclr_10");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
